// File: rtl/match_prio_enc_if.sv
// Handshake bundle between the TCAM match stage and the priority encoder.
// Upstream and result sides are grouped so the encoder sees a single port.
interface match_prio_enc_if #(
    parameter int TCAM_DEPTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic [TCAM_DEPTH-1:0] match_line;
    logic                  match_valid;
    logic                  match_ready;
    logic [ADDR_WIDTH-1:0] result_addr;
    logic                  result_hit;
    logic                  result_valid;
    logic                  result_ready;

    modport master (
        output match_line, match_valid, result_ready,
        input  match_ready, result_addr, result_hit, result_valid
    );

    modport slave (
        input  match_line, match_valid, result_ready,
        output match_ready, result_addr, result_hit, result_valid
    );
endinterface

// File: rtl/match_prio_enc.sv
// Segmented priority encoder for a TCAM match line: scans SEG_WIDTH bits per cycle
// and reports the lowest-index set bit, stopping at the first segment that hits.
module match_prio_enc #(
    parameter int TCAM_DEPTH = 16,
    parameter int SEG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rst,
    match_prio_enc_if.slave     bus
);
    localparam int NUM_SEG   = (TCAM_DEPTH + SEG_WIDTH - 1) / SEG_WIDTH;
    localparam int PAD_WIDTH = NUM_SEG * SEG_WIDTH;
    localparam int SEG_IDX_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam int SEG_BIT_W = (SEG_WIDTH > 1) ? $clog2(SEG_WIDTH) : 1;

    if (ADDR_WIDTH < $clog2(TCAM_DEPTH)) begin : g_addr_width_check
        $error("match_prio_enc: ADDR_WIDTH too small for TCAM_DEPTH");
    end

    typedef enum logic [1:0] {IDLE, SCAN, OUT} state_e;

    state_e                state_q,   state_d;
    logic [SEG_IDX_W-1:0]  seg_idx_q, seg_idx_d;
    logic [PAD_WIDTH-1:0]  line_q,    line_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic                  hit_q,     hit_d;

    logic [SEG_WIDTH-1:0]  seg;
    logic [SEG_BIT_W-1:0]  low_bit;
    logic [ADDR_WIDTH-1:0] hit_addr;
    logic                  last_seg;

    // Lowest set bit in the current segment: descending loop so the smallest index wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        seg     = line_q[seg_idx_q*SEG_WIDTH +: SEG_WIDTH];
        low_bit = '0;
        for (int i = SEG_WIDTH - 1; i >= 0; i--) begin
            if (seg[i]) low_bit = SEG_BIT_W'(i);
        end
        hit_addr = ADDR_WIDTH'(seg_idx_q) * ADDR_WIDTH'(SEG_WIDTH) + ADDR_WIDTH'(low_bit);
        last_seg = (seg_idx_q == SEG_IDX_W'(NUM_SEG - 1));
    end

    always_comb begin
        state_d   = state_q;
        seg_idx_d = seg_idx_q;
        line_d    = line_q;
        addr_d    = addr_q;
        hit_d     = hit_q;
        case (state_q)
            IDLE: begin
                if (bus.match_valid) begin
                    line_d    = PAD_WIDTH'(bus.match_line);
                    seg_idx_d = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (|seg) begin
                    addr_d  = hit_addr;
                    hit_d   = 1'b1;
                    state_d = OUT;
                end else if (last_seg) begin
                    addr_d  = '0;
                    hit_d   = 1'b0;
                    state_d = OUT;
                end else begin
                    seg_idx_d = seg_idx_q + SEG_IDX_W'(1);
                end
            end
            OUT: begin
                if (bus.result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            seg_idx_q <= '0;
            line_q    <= '0;
            addr_q    <= '0;
            hit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            seg_idx_q <= seg_idx_d;
            line_q    <= line_d;
            addr_q    <= addr_d;
            hit_q     <= hit_d;
        end
    end

    // Outputs come straight from flops or the state register only.
    assign bus.match_ready  = (state_q == IDLE);
    assign bus.result_valid = (state_q == OUT);
    assign bus.result_addr  = addr_q;
    assign bus.result_hit   = hit_q;
endmodule
